// File: rtl/vga_timing.sv
// VGA raster timing generator: single-clock h/v counters with registered
// sync/blank decode, line/frame strobes and a clk-cycle delay line on sync/blank.
//
// Ports:
//   clk, reset (sync, active-high), pix_en (pixel advance enable)
//   hcount/vcount    current pixel column / line
//   hsync/vsync/blank_n   decoded for the hcount/vcount shown on the same cycle
//   line_start/frame_start  one-clk strobes when the position becomes (0,*)/(0,0)
//   hsync_d/vsync_d/blank_n_d   sync/blank delayed PIPE_DELAY clk cycles
module vga_timing #(
    parameter int H_ACTIVE   = 200,
    parameter int H_FP       = 10,
    parameter int H_SYNC     = 32,
    parameter int H_BP       = 22,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter int SYNC_POL   = 1,
    parameter int PIPE_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       line_start,
    output logic       frame_start,
    output logic       hsync_d,
    output logic       vsync_d,
    output logic       blank_n_d
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // 11-bit thresholds so an active width of 1024 still compares correctly
    localparam logic [10:0] H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] H_S_LO  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_S_HI  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [10:0] V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] V_S_LO  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_S_HI  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam logic SYNC_ON  = (SYNC_POL != 0);
    localparam logic SYNC_OFF = !SYNC_ON;

    logic [9:0] hcount_q, hcount_d;
    logic [9:0] vcount_q, vcount_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       bl_q, bl_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic       h_wrap, v_wrap;
    logic [10:0] h_ext, v_ext;

    always_comb begin
        h_wrap   = (hcount_q == H_LAST);
        v_wrap   = (vcount_q == V_LAST);
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        ls_d     = 1'b0;
        fs_d     = 1'b0;
        if (pix_en) begin
            hcount_d = h_wrap ? 10'd0 : hcount_q + 10'd1;
            if (h_wrap) begin
                vcount_d = v_wrap ? 10'd0 : vcount_q + 10'd1;
            end
            ls_d = h_wrap;
            fs_d = h_wrap && v_wrap;
        end
        // Decode from the next position so the registered flags line up
        // with the counter values they describe.
        h_ext = {1'b0, hcount_d};
        v_ext = {1'b0, vcount_d};
        hs_d  = (h_ext >= H_S_LO && h_ext <= H_S_HI) ? SYNC_ON : SYNC_OFF;
        vs_d  = (v_ext >= V_S_LO && v_ext <= V_S_HI) ? SYNC_ON : SYNC_OFF;
        bl_d  = (h_ext < H_ACT) && (v_ext < V_ACT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q <= H_LAST;
            vcount_q <= V_LAST;
            hs_q     <= SYNC_OFF;
            vs_q     <= SYNC_OFF;
            bl_q     <= 1'b0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            bl_q     <= bl_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign blank_n     = bl_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

    // Delay line runs every clk (ROM latency is in clk cycles, not pixels).
    if (PIPE_DELAY == 0) begin : g_nopipe
        assign hsync_d   = hs_q;
        assign vsync_d   = vs_q;
        assign blank_n_d = bl_q;
    end else begin : g_pipe
        logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
        logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
        logic [PIPE_DELAY-1:0] bl_pipe_q, bl_pipe_d;

        always_comb begin
            hs_pipe_d[0] = hs_q;
            vs_pipe_d[0] = vs_q;
            bl_pipe_d[0] = bl_q;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                hs_pipe_d[i] = hs_pipe_q[i-1];
                vs_pipe_d[i] = vs_pipe_q[i-1];
                bl_pipe_d[i] = bl_pipe_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                hs_pipe_q <= {PIPE_DELAY{SYNC_OFF}};
                vs_pipe_q <= {PIPE_DELAY{SYNC_OFF}};
                bl_pipe_q <= '0;
            end else begin
                hs_pipe_q <= hs_pipe_d;
                vs_pipe_q <= vs_pipe_d;
                bl_pipe_q <= bl_pipe_d;
            end
        end

        assign hsync_d   = hs_pipe_q[PIPE_DELAY-1];
        assign vsync_d   = vs_pipe_q[PIPE_DELAY-1];
        assign blank_n_d = bl_pipe_q[PIPE_DELAY-1];
    end

endmodule
